// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and byte/word helpers
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CALC  = 2'd2
    } state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box: multiplicative inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // {a0, a1, a2, a3} -> {a1, a2, a3, a0}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_expand_sub_word.sv
// rtl/key_expand_sub_word.sv - combinational SubWord, four parallel S-box lookups
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/key_expand.sv
// rtl/key_expand.sv - AES-128 key expansion, one round key every two cycles
module key_expand #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic [3:0]   rcon_addr,
    input  logic [31:0]  rcon_dout,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    output logic         last,
    output logic         busy
);

    localparam logic [3:0] LAST_PREV = 4'(NR - 1);

    aes_pkg::state_e state_q, state_d;
    logic [127:0]    round_key_q, round_key_d;
    logic [3:0]      round_idx_q, round_idx_d;
    logic [3:0]      rcon_addr_q, rcon_addr_d;
    logic            rk_valid_q, rk_valid_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;

    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] t_w;
    logic [31:0] n0, n1, n2, n3;

    assign rot_w = aes_pkg::rot_word(round_key_q[31:0]);

    sub_word u_sub_word (
        .word_i (rot_w),
        .word_o (sub_w)
    );

    // rcon_dout is only meaningful in CALC, one cycle after FETCH presented the address.
    assign t_w = sub_w ^ rcon_dout;
    assign n0  = round_key_q[127:96] ^ t_w;
    assign n1  = round_key_q[95:64]  ^ n0;
    assign n2  = round_key_q[63:32]  ^ n1;
    assign n3  = round_key_q[31:0]   ^ n2;

    // State and output registers; reset clears everything so no stream resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= aes_pkg::ST_IDLE;
            round_key_q <= '0;
            round_idx_q <= '0;
            rcon_addr_q <= '0;
            rk_valid_q  <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            rcon_addr_q <= rcon_addr_d;
            rk_valid_q  <= rk_valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: IDLE accepts start, FETCH waits on the ROM, CALC emits the next round key.
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        rcon_addr_d = rcon_addr_q;
        rk_valid_d  = 1'b0;
        last_d      = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            aes_pkg::ST_IDLE: begin
                if (start) begin
                    round_key_d = key;
                    round_idx_d = 4'd0;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    rcon_addr_d = 4'd1;
                    state_d     = aes_pkg::ST_FETCH;
                end
            end
            aes_pkg::ST_FETCH: begin
                state_d = aes_pkg::ST_CALC;
            end
            aes_pkg::ST_CALC: begin
                round_key_d = {n0, n1, n2, n3};
                round_idx_d = round_idx_q + 4'd1;
                rk_valid_d  = 1'b1;
                if (round_idx_q == LAST_PREV) begin
                    last_d      = 1'b1;
                    busy_d      = 1'b0;
                    rcon_addr_d = 4'd0;
                    state_d     = aes_pkg::ST_IDLE;
                end else begin
                    rcon_addr_d = rcon_addr_q + 4'd1;
                    state_d     = aes_pkg::ST_FETCH;
                end
            end
            default: begin
                state_d = aes_pkg::ST_IDLE;
            end
        endcase
    end

    assign rcon_addr = rcon_addr_q;
    assign round_key = round_key_q;
    assign round_idx = round_idx_q;
    assign rk_valid  = rk_valid_q;
    assign last      = last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_key_expand.sv
// tb/tb_key_expand.sv - randomized self-checking bench for key_expand
module tb_key_expand;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [31:0]  rcon_dout = '0;
    logic [3:0]   rcon_addr;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         last;
    logic         busy;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    logic [7:0] sb [0:255];

    always #5 clk = ~clk;

    key_expand #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .rcon_addr (rcon_addr),
        .rcon_dout (rcon_dout),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .last      (last),
        .busy      (busy)
    );

    function automatic logic [31:0] rcon_rom(input logic [3:0] a);
        logic [7:0] rc [0:10];
        rc = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        if (a > 4'd10) return 32'h0;
        return {rc[a], 24'h0};
    endfunction

    // registered rcon ROM beside the engine
    always @(posedge clk) rcon_dout <= rcon_rom(rcon_addr);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 0;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    // textbook 44-word schedule, returns round r
    function automatic logic [127:0] round_key_of(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // behavioural model: elapsed edges since acceptance decide what is visible
    logic [127:0] m_run_key = '0, m_key = '0;
    logic [3:0]   m_idx = '0, m_addr = '0;
    logic         m_valid = 0, m_last = 0, m_busy = 0, m_active = 0;
    int           m_el = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key = '0; m_idx = '0; m_addr = '0;
            m_valid = 0; m_last = 0; m_busy = 0; m_active = 0; m_el = 0;
        end else if (m_active) begin
            m_el++;
            if (m_el % 2 == 0) begin
                m_key   = round_key_of(m_run_key, m_el / 2);
                m_idx   = 4'(m_el / 2);
                m_valid = 1;
                m_last  = (m_el == 20);
                m_busy  = (m_el != 20);
                m_addr  = (m_el == 20) ? 4'd0 : 4'(m_el / 2 + 1);
                if (m_el == 20) m_active = 0;
            end else begin
                m_valid = 0;
                m_last  = 0;
            end
        end else begin
            m_valid = 0;
            m_last  = 0;
            if (start) begin
                m_run_key = key;
                m_key = key; m_idx = 0; m_addr = 1;
                m_valid = 1; m_busy = 1; m_active = 1; m_el = 0;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en)
            check("cycle", {round_key, round_idx, rcon_addr, rk_valid, last, busy},
                           {m_key, m_idx, m_addr, m_valid, m_last, m_busy});
    end

    int         pulse_cnt = 0;
    logic [3:0] addr_seq [0:15];
    always @(negedge clk) begin
        if (rk_valid) begin
            if (pulse_cnt < 16) addr_seq[pulse_cnt] = rcon_addr;
            pulse_cnt++;
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // drive start for one cycle; returns at the negedge after the accepting edge
    task automatic kick(input logic [127:0] k);
        @(negedge clk);
        key = k;
        start = 1;
        @(negedge clk);
        start = 0;
        key = rnd128();
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial begin
        logic [127:0] k2;
        logic [127:0] saved;

        build_sbox();
        check("sbox_00", sb[0], 8'h63);
        check("sbox_53", sb[8'h53], 8'hed);
        check("model_fips_r1", round_key_of(FIPS_KEY, 1), FIPS_R1);
        check("model_zero_r10", round_key_of(128'h0, 10), ZERO_R10);

        @(posedge clk);
        #1 cmp_en = 1;
        @(negedge clk);
        check("reset_state", {round_key, round_idx, rcon_addr, rk_valid, last, busy}, 0);
        rst_n = 1;

        // FIPS-197 A.1 vector with literal timing
        kick(FIPS_KEY);
        check("fips_r0", {round_key, round_idx, rk_valid, busy}, {FIPS_KEY, 4'd0, 1'b1, 1'b1});
        repeat (2) @(negedge clk);
        check("fips_r1", {round_key, round_idx, rk_valid}, {FIPS_R1, 4'd1, 1'b1});
        repeat (18) @(negedge clk);
        check("fips_r10", {round_key, round_idx, rk_valid, last, busy, rcon_addr},
                          {FIPS_R10, 4'd10, 1'b1, 1'b1, 1'b0, 4'd0});
        repeat (3) @(negedge clk);

        // all-zero key, plus pulse count and address sequence
        pulse_cnt = 0;
        kick(128'h0);
        check("zero_r0", {round_key, round_idx}, {128'h0, 4'd0});
        repeat (2) @(negedge clk);
        check("zero_r1", round_key, ZERO_R1);
        repeat (18) @(negedge clk);
        check("zero_r10", {round_key, last}, {ZERO_R10, 1'b1});
        repeat (4) @(negedge clk);
        check("pulse_count", pulse_cnt, 11);
        for (int r = 0; r < 11; r++)
            check($sformatf("addr_after_r%0d", r), addr_seq[r], (r == 10) ? 4'd0 : 4'(r + 1));

        // start during round 3 CALC and round 10 CALC; key changes mid-run
        kick(rnd128());
        repeat (5) @(negedge clk);
        start = 1; key = rnd128();
        @(negedge clk);
        start = 0;
        repeat (13) @(negedge clk);
        k2 = rnd128();
        start = 1; key = k2;
        @(negedge clk);
        check("busy_ignore_r10", {round_idx, last}, {4'd10, 1'b1});
        @(negedge clk);
        start = 0;
        check("accept_t21", {round_key, round_idx, rk_valid}, {k2, 4'd0, 1'b1});
        repeat (24) @(negedge clk);

        // async reset after round 5
        kick(rnd128());
        repeat (11) @(negedge clk);
        #2 rst_n = 0;
        #1 check("async_reset", {round_key, round_idx, rcon_addr, rk_valid, last, busy}, 0);
        @(negedge clk);
        check("reset_held", {round_key, round_idx, rcon_addr, rk_valid, last, busy}, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("no_resume", {rk_valid, busy}, 2'b00);
        kick(rnd128());
        repeat (23) @(negedge clk);

        // start held high for 50 cycles: runs at T, T+21, T+42
        @(negedge clk);
        start = 1;
        for (int i = 0; i < 50; i++) begin
            key = rnd128();
            saved = key;
            @(negedge clk);
            if (i % 21 == 0)
                check($sformatf("held_run_%0d", i / 21), {round_key, round_idx, rk_valid},
                      {saved, 4'd0, 1'b1});
        end
        start = 0;
        repeat (25) @(negedge clk);

        // random keys with random idle gaps
        for (int n = 0; n < 4; n++) begin
            kick(rnd128());
            repeat (20 + $urandom_range(0, 5)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
